retire_map: RTL



---
 rtl/retire_map_pkg.sv | 13 +
 rtl/retire_map_free_fifo.sv | 80 ++++++++
 rtl/retire_map.sv | 94 +++++++++
 3 files changed

// File: rtl/retire_map_pkg.sv
// Shared rename constants and index types used by the retirement map,
// the free list and the speculative rename map.
package retire_map_pkg;

  localparam int ARCH_REGS = 32;
  localparam int PREG_W    = 6;
  localparam int NUM_PREGS = 64;
  localparam int AREG_W    = 5;

  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/retire_map_free_fifo.sv
// Dual-push, single-pop circular buffer holding physical registers on their
// way back to the free list; drains one entry every cycle it is non-empty.
module free_return_fifo
  import retire_map_pkg::*;
#(
  parameter int W     = 6,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push_a,
  input  logic [W-1:0]     data_a,
  input  logic             push_b,
  input  logic [W-1:0]     data_b,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic [W-1:0]     head_data
);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [1:0]       n_push_s;
  logic [W-1:0]     first_s;
  logic             pop_s;

  // Compact the two push requests so a lone slot-b push lands at the tail
  always_comb begin
    pop_s = (count_r != CNT_W'(0));
    if (push_a && push_b) begin
      n_push_s = 2'd2;
      first_s  = data_a;
    end else if (push_a) begin
      n_push_s = 2'd1;
      first_s  = data_a;
    end else if (push_b) begin
      n_push_s = 2'd1;
      first_s  = data_b;
    end else begin
      n_push_s = 2'd0;
      first_s  = data_a;
    end
  end

  // Storage, pointers and occupancy; clear empties the buffer without touching data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= W'(0);
      head_r  <= PTR_W'(0);
      tail_r  <= PTR_W'(0);
      count_r <= CNT_W'(0);
    end else if (clear) begin
      head_r  <= PTR_W'(0);
      tail_r  <= PTR_W'(0);
      count_r <= CNT_W'(0);
    end else begin
      if (n_push_s != 2'd0) mem_r[tail_r] <= first_s;
      if (n_push_s == 2'd2) mem_r[tail_r + PTR_W'(1)] <= data_b;
      tail_r  <= tail_r + PTR_W'(n_push_s);
      head_r  <= head_r + PTR_W'(pop_s);
      count_r <= count_r + CNT_W'(n_push_s) - CNT_W'(pop_s);
    end
  end

  // Head presentation decoded straight from registered state
  always_comb begin
    count = count_r;
    valid = pop_s;
    if (pop_s) begin
      head_data = mem_r[head_r];
    end else begin
      head_data = W'(0);
    end
  end

endmodule

// File: rtl/retire_map.sv
// Retirement register alias table: holds the committed arch-to-phys mapping
// and returns each overwritten physical register to the free list.
module retire_map
  import retire_map_pkg::*;
#(
  parameter int ARCH_REGS  = 32,
  parameter int PREG_W     = 6,
  parameter int FREE_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             commit0_valid,
  input  logic                             commit0_wr,
  input  areg_t                            commit0_areg,
  input  logic [PREG_W-1:0]                commit0_preg,
  input  logic                             commit1_valid,
  input  logic                             commit1_wr,
  input  areg_t                            commit1_areg,
  input  logic [PREG_W-1:0]                commit1_preg,
  output logic                             commit_ready,
  output logic                             free_enque,
  output logic [PREG_W-1:0]                free_data,
  output logic [ARCH_REGS-1:0][PREG_W-1:0] r_mapping,
  output logic [31:0]                      retired_count
);

  localparam int CNT_W = $clog2(FREE_DEPTH) + 1;

  logic [ARCH_REGS-1:0][PREG_W-1:0] map_r;
  logic [31:0]                      retired_r;
  logic [CNT_W-1:0]                 count_s;
  logic                             acc0_s;
  logic                             acc1_s;
  logic                             wr0_s;
  logic                             wr1_s;
  logic [PREG_W-1:0]                old0_s;
  logic [PREG_W-1:0]                old1_s;

  // Acceptance, effective writes and old-register lookup; slot 1 sees slot 0's
  // new mapping when both retire to the same architectural register
  always_comb begin
    commit_ready = (count_s <= CNT_W'(FREE_DEPTH - 2));
    acc0_s       = commit0_valid && commit_ready && !flush;
    acc1_s       = acc0_s && commit1_valid;
    wr0_s        = acc0_s && commit0_wr && (commit0_areg != 5'd0);
    wr1_s        = acc1_s && commit1_wr && (commit1_areg != 5'd0);
    old0_s       = map_r[commit0_areg];
    if (wr0_s && (commit0_areg == commit1_areg)) begin
      old1_s = commit0_preg;
    end else begin
      old1_s = map_r[commit1_areg];
    end
  end

  // Committed mapping; the later slot's write takes effect last
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ARCH_REGS; i++) map_r[i] <= PREG_W'(i);
    end else begin
      if (wr0_s) map_r[commit0_areg] <= commit0_preg;
      if (wr1_s) map_r[commit1_areg] <= commit1_preg;
    end
  end

  // Count of accepted slots, including ones without a destination
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_r <= 32'd0;
    end else begin
      retired_r <= retired_r + 32'(acc0_s) + 32'(acc1_s);
    end
  end

  free_return_fifo #(
    .W     (PREG_W),
    .DEPTH (FREE_DEPTH)
  ) u_free_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push_a    (wr0_s),
    .data_a    (old0_s),
    .push_b    (wr1_s),
    .data_b    (old1_s),
    .count     (count_s),
    .valid     (free_enque),
    .head_data (free_data)
  );

  assign r_mapping     = map_r;
  assign retired_count = retired_r;

endmodule
